// File: rtl/cache_arbiter_pkg.sv
// Shared types and constants for the cache-line memory port arbiter.
// States are plain logic constants so they read identically in RTL, bench and waveforms.
package cache_arbiter_pkg;

  localparam int LINE_BITS = 256;

  typedef logic [1:0] arb_state_t;

  localparam arb_state_t ST_IDLE    = 2'd0;
  localparam arb_state_t ST_SERVE_I = 2'd1;
  localparam arb_state_t ST_SERVE_D = 2'd2;
  localparam arb_state_t ST_RECOVER = 2'd3;

  // Owner of the most recent grant; a tie goes to the opposite side.
  localparam logic GRANT_I = 1'b0;
  localparam logic GRANT_D = 1'b1;

endpackage

// File: rtl/cache_arbiter.sv
// Shares one cache-line memory port between the icache and dcache: one grant at a time,
// alternating priority on ties, latched request, response steered back to its owner.
module cache_arbiter
  import cache_arbiter_pkg::*;
#(
  parameter int LINE_W = LINE_BITS,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_resp,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_resp,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [ADDR_W-1:0] pmem_address,
  output logic [LINE_W-1:0] pmem_wdata,
  input  logic [LINE_W-1:0] pmem_rdata,
  input  logic              pmem_resp,
  output logic [1:0]        state_dbg
);

  arb_state_t        state_q, state_d;
  logic              last_grant_q, last_grant_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LINE_W-1:0] wdata_q, wdata_d;
  logic              op_write_q, op_write_d;

  logic i_req;
  logic d_req;
  logic grant_d_side;
  logic serving;

  // Handshake: each cache holds its request until its one-cycle resp; the memory holds
  // pmem_resp for exactly one cycle while a strobe is up. RECOVER gives the cache a
  // cycle to drop the finished request before the next IDLE decision.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    op_write_d   = op_write_q;

    i_req        = i_read;
    d_req        = d_read | d_write;
    grant_d_side = d_req & (~i_req | (last_grant_q == GRANT_I));

    case (state_q)
      ST_IDLE: begin
        if (grant_d_side) begin
          state_d      = ST_SERVE_D;
          last_grant_d = GRANT_D;
          addr_d       = d_addr;
          wdata_d      = d_wdata;
          op_write_d   = d_write;
        end else if (i_req) begin
          state_d      = ST_SERVE_I;
          last_grant_d = GRANT_I;
          addr_d       = i_addr;
          op_write_d   = 1'b0;
        end
      end
      ST_SERVE_I, ST_SERVE_D: begin
        if (pmem_resp) begin
          state_d = ST_RECOVER;
        end
      end
      ST_RECOVER: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      last_grant_q <= GRANT_I;
      addr_q       <= '0;
      wdata_q      <= '0;
      op_write_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      op_write_q   <= op_write_d;
    end
  end

  always_comb begin
    serving      = (state_q == ST_SERVE_I) | (state_q == ST_SERVE_D);
    pmem_read    = serving & ~op_write_q;
    pmem_write   = serving & op_write_q;
    pmem_address = addr_q;
    pmem_wdata   = wdata_q;
    i_resp       = (state_q == ST_SERVE_I) & pmem_resp;
    d_resp       = (state_q == ST_SERVE_D) & pmem_resp;
    i_rdata      = pmem_rdata;
    d_rdata      = pmem_rdata;
    state_dbg    = state_q;
  end

endmodule
